// File: rtl/user_io_pkg.sv
// Shared definitions for the user I/O controller: register offsets,
// field width and the byte-lane merge helper used by every writable register.
package user_io_pkg;

  localparam int FIELD_W = 64;

  localparam logic [7:0] OFS_OUT_LO  = 8'h00;
  localparam logic [7:0] OFS_OUT_HI  = 8'h04;
  localparam logic [7:0] OFS_OEB_LO  = 8'h08;
  localparam logic [7:0] OFS_OEB_HI  = 8'h0C;
  localparam logic [7:0] OFS_IN_LO   = 8'h10;
  localparam logic [7:0] OFS_IN_HI   = 8'h14;
  localparam logic [7:0] OFS_IE_LO   = 8'h18;
  localparam logic [7:0] OFS_IE_HI   = 8'h1C;
  localparam logic [7:0] OFS_STAT_LO = 8'h20;
  localparam logic [7:0] OFS_STAT_HI = 8'h24;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_io_ctrl_if.sv
// Wishbone slave bus bundle between the management core and the user I/O block.
interface user_io_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/io_sync_edge.sv
// Pad input synchroniser with a trailing previous-sample flop, producing the
// synchronised value and a one-cycle rising-edge pulse per bit.
module io_sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync_val,
  output logic [W-1:0] rise
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;

  // Shift the pads through the synchroniser chain and keep one older sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign sync_val = chain[STAGES-1];
  assign rise     = sync_val & ~prev;

endmodule

// File: rtl/user_io_ctrl.sv
// Wishbone-controlled GPIO block: output/enable registers with a logic-analyser
// override, synchronised inputs, per-pin rising-edge status and a level interrupt.
module user_io_ctrl
  import user_io_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  user_io_ctrl_if.slave     wbs,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  input  logic              la_ovr_en,
  input  logic [NUM_IO-1:0] la_ovr_out,
  output logic              user_irq
);

  // Bits at or above NUM_IO never hold state and always read back as zero.
  localparam logic [FIELD_W-1:0] VALID =
    (NUM_IO >= FIELD_W) ? {FIELD_W{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [FIELD_W-1:0] out_q, oeb_q, ie_q, stat_q;
  logic [FIELD_W-1:0] out_d, oeb_d, ie_d, stat_d, w1c;
  logic [FIELD_W-1:0] in_full, rise_full;
  logic [NUM_IO-1:0]  sync_val, rise;
  logic [31:0]        dat_q, rd_data;
  logic               ack_q, irq_q;
  logic [2:0]         arm_cnt;
  logic               armed, win_hit, req;
  logic [7:0]         ofs_w;

  io_sync_edge #(.W(NUM_IO), .STAGES(SYNC_STAGES)) u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .din      (io_in),
    .sync_val (sync_val),
    .rise     (rise)
  );

  // Zero-extend the pad-wide vectors to the full 64-bit field layout.
  always_comb begin
    in_full   = '0;
    rise_full = '0;
    in_full[NUM_IO-1:0]   = sync_val;
    rise_full[NUM_IO-1:0] = rise;
  end

  assign win_hit = (wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & win_hit & ~ack_q;
  assign ofs_w   = {wbs.wbs_adr_i[7:2], 2'b00};
  assign armed   = (arm_cnt == ARM_DONE);

  // Read mux over the register map; unmapped offsets return zero.
  always_comb begin
    rd_data = '0;
    case (ofs_w)
      OFS_OUT_LO:  rd_data = out_q[31:0];
      OFS_OUT_HI:  rd_data = out_q[63:32];
      OFS_OEB_LO:  rd_data = oeb_q[31:0];
      OFS_OEB_HI:  rd_data = oeb_q[63:32];
      OFS_IN_LO:   rd_data = in_full[31:0];
      OFS_IN_HI:   rd_data = in_full[63:32];
      OFS_IE_LO:   rd_data = ie_q[31:0];
      OFS_IE_HI:   rd_data = ie_q[63:32];
      OFS_STAT_LO: rd_data = stat_q[31:0];
      OFS_STAT_HI: rd_data = stat_q[63:32];
      default:     rd_data = '0;
    endcase
  end

  // Next register values from a byte-masked write; STAT lanes form a clear mask.
  always_comb begin
    out_d = out_q;
    oeb_d = oeb_q;
    ie_d  = ie_q;
    w1c   = '0;
    if (req && wbs.wbs_we_i) begin
      case (ofs_w)
        OFS_OUT_LO:  out_d[31:0]  = byte_merge(out_q[31:0],  wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_OUT_HI:  out_d[63:32] = byte_merge(out_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_OEB_LO:  oeb_d[31:0]  = byte_merge(oeb_q[31:0],  wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_OEB_HI:  oeb_d[63:32] = byte_merge(oeb_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_IE_LO:   ie_d[31:0]   = byte_merge(ie_q[31:0],   wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_IE_HI:   ie_d[63:32]  = byte_merge(ie_q[63:32],  wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_STAT_LO: w1c[31:0]    = byte_merge(32'h0, wbs.wbs_dat_i, wbs.wbs_sel_i);
        OFS_STAT_HI: w1c[63:32]   = byte_merge(32'h0, wbs.wbs_dat_i, wbs.wbs_sel_i);
        default: ;
      endcase
    end
    out_d = out_d & VALID;
    oeb_d = oeb_d & VALID;
    ie_d  = ie_d  & VALID;
  end

  // A new edge beats a simultaneous clear of the same bit.
  assign stat_d = ((stat_q & ~w1c) | (armed ? rise_full : '0)) & VALID;

  // Saturating count that keeps edge capture off until the synchroniser has filled.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)              arm_cnt <= '0;
    else if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + 3'd1;
  end

  // Register file, bus response and interrupt level.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q  <= '0;
      oeb_q  <= VALID;
      ie_q   <= '0;
      stat_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      ie_q   <= ie_d;
      stat_q <= stat_d;
      ack_q  <= req;
      if (req && !wbs.wbs_we_i) dat_q <= rd_data;
      irq_q  <= |(stat_q & ie_q);
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign io_out        = la_ovr_en ? la_ovr_out : out_q[NUM_IO-1:0];
  assign io_oeb        = oeb_q[NUM_IO-1:0];
  assign user_irq      = irq_q;

endmodule

// File: tb/tb_user_io_ctrl.sv
// Self-checking bench for user_io_ctrl: register table, edge capture, W1C races,
// override path, window decode and reset behaviour.
module tb_user_io_ctrl;

  localparam int          NUM_IO = 38;
  localparam int          SYNC   = 2;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_IO-1:0] io_in, io_out, io_oeb, la_ovr_out;
  logic              la_ovr_en, user_irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  typedef struct {
    logic [7:0]  ofs;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[10];

  user_io_ctrl_if bus();

  user_io_ctrl #(
    .NUM_IO(NUM_IO), .SYNC_STAGES(SYNC), .BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FF00)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs        (bus.slave),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .la_ovr_en  (la_ovr_en),
    .la_ovr_out (la_ovr_out),
    .user_irq   (user_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp_v);
    end
  endtask

  // One bus access starting just after a falling edge; waits at most 8 cycles for ack.
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic acked, output logic [31:0] rd);
    acked = 1'b0;
    rd    = '0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rd    = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input string name);
    logic        acked;
    logic [31:0] rd;
    wb_access(1'b1, adr, dat, sel, acked, rd);
    checkOutput({name, "_ack"}, 64'(acked), 64'd1);
  endtask

  // Reads push their expectation when issued and pop it when the ack returns data.
  task automatic read_reg(input logic [31:0] adr, input logic [31:0] expv, input string name);
    logic        acked;
    logic [31:0] rd;
    exp_q.push_back(expv);
    tag_q.push_back(name);
    wb_access(1'b0, adr, 32'h0, 4'hF, acked, rd);
    if (!acked) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: actual=no_ack required=ack", tag_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      checkOutput(tag_q.pop_front(), 64'(rd), 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    int          ack_cnt;
    logic        b2b, prev_ack, acked;
    logic [31:0] rd;

    vecs[0] = '{8'h00, 4'b0011, 32'hA5A5_A5A5, 32'h0000_A5A5};
    vecs[1] = '{8'h04, 4'b1111, 32'hFFFF_FFFF, 32'h0000_003F};
    vecs[2] = '{8'h08, 4'b1111, 32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{8'h08, 4'b1000, 32'hFFFF_FFFF, 32'hFF34_5678};
    vecs[4] = '{8'h0C, 4'b1111, 32'hFFFF_FF00, 32'h0000_0000};
    vecs[5] = '{8'h1C, 4'b0001, 32'hFFFF_FFFF, 32'h0000_003F};
    vecs[6] = '{8'h18, 4'b0110, 32'h1234_5678, 32'h0034_5600};
    vecs[7] = '{8'h10, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{8'h28, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9] = '{8'hFC, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    rst = 1'b1; io_in = '1; la_ovr_en = 1'b0; la_ovr_out = '0;

    // Reset state with every pad held high.
    repeat (3) @(negedge clk);
    checkOutput("rst_ack",  64'(bus.wbs_ack_o), 64'd0);
    checkOutput("rst_dat",  64'(bus.wbs_dat_o), 64'd0);
    checkOutput("rst_irq",  64'(user_irq), 64'd0);
    checkOutput("rst_oeb",  64'(io_oeb), 64'h3F_FFFF_FFFF);
    checkOutput("rst_out",  64'(io_out), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    read_reg(BASE + 32'h20, 32'h0, "arm_stat_lo");
    read_reg(BASE + 32'h24, 32'h0, "arm_stat_hi");
    read_reg(BASE + 32'h10, 32'hFFFF_FFFF, "in_lo_high");
    read_reg(BASE + 32'h14, 32'h0000_003F, "in_hi_high");
    checkOutput("arm_irq", 64'(user_irq), 64'd0);
    io_in = '0;
    repeat (4) @(negedge clk);

    // Register table: write, then read back.
    foreach (vecs[i]) begin
      applyStimulus(BASE | {24'h0, vecs[i].ofs}, vecs[i].wdata, vecs[i].sel, $sformatf("vec%0d_wr", i));
      read_reg(BASE | {24'h0, vecs[i].ofs}, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
    end
    checkOutput("tbl_io_out", 64'(io_out), 64'h3F_0000_A5A5);
    checkOutput("tbl_io_oeb", 64'(io_oeb), 64'h00_FF34_5678);

    // Rising edge on pad 0 through to the interrupt and its clear.
    applyStimulus(BASE + 32'h18, 32'h1, 4'hF, "ie_lo");
    io_in[0] = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    checkOutput("irq_before", 64'(user_irq), 64'd0);
    @(negedge clk);
    checkOutput("irq_rise", 64'(user_irq), 64'd1);
    read_reg(BASE + 32'h20, 32'h1, "stat_bit0");
    applyStimulus(BASE + 32'h20, 32'h1, 4'hF, "w1c_bit0");
    checkOutput("irq_during_ack", 64'(user_irq), 64'd1);
    @(negedge clk);
    checkOutput("irq_cleared", 64'(user_irq), 64'd0);
    read_reg(BASE + 32'h20, 32'h0, "stat_after_w1c");

    // Clear of bit 5 committed on the same edge that captures its rise.
    io_in[5] = 1'b1;
    repeat (SYNC) @(negedge clk);
    applyStimulus(BASE + 32'h20, 32'h20, 4'hF, "w1c_race");
    read_reg(BASE + 32'h20, 32'h20, "stat_race_set_wins");
    applyStimulus(BASE + 32'h20, 32'h20, 4'hF, "w1c_bit5");
    read_reg(BASE + 32'h20, 32'h0, "stat_bit5_clear");

    // Byte-lane masking on W1C.
    io_in[1] = 1'b1; io_in[9] = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    read_reg(BASE + 32'h20, 32'h202, "stat_bits_1_9");
    applyStimulus(BASE + 32'h20, 32'h202, 4'b0001, "w1c_lane0");
    read_reg(BASE + 32'h20, 32'h200, "stat_lane0_only");
    applyStimulus(BASE + 32'h20, 32'h202, 4'b0010, "w1c_lane1");
    read_reg(BASE + 32'h20, 32'h0, "stat_lane1");

    // Logic-analyser override affects io_out only.
    la_ovr_en = 1'b1; la_ovr_out = 38'h15;
    @(negedge clk);
    checkOutput("ovr_io_out", 64'(io_out), 64'h15);
    checkOutput("ovr_io_oeb", 64'(io_oeb), 64'h00_FF34_5678);
    read_reg(BASE + 32'h00, 32'h0000_A5A5, "ovr_out_reg");
    la_ovr_en = 1'b0;
    @(negedge clk);
    checkOutput("ovr_off_io_out", 64'(io_out), 64'h3F_0000_A5A5);

    // Outside the window: no ack and no write.
    wb_access(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, acked, rd);
    checkOutput("outside_ack", 64'(acked), 64'd0);
    wb_access(1'b1, 32'h3100_0000, 32'hFFFF_FFFF, 4'hF, acked, rd);
    checkOutput("outside2_ack", 64'(acked), 64'd0);
    read_reg(BASE + 32'h00, 32'h0000_A5A5, "outside_no_write");

    // Held strobe acknowledges every other cycle.
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE; bus.wbs_sel_i = 4'hF;
    ack_cnt = 0; b2b = 1'b0; prev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        ack_cnt++;
        if (prev_ack) b2b = 1'b1;
      end
      prev_ack = bus.wbs_ack_o;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    checkOutput("held_acks", 64'(ack_cnt), 64'd3);
    checkOutput("held_b2b",  64'(b2b), 64'd0);
    @(negedge clk);

    // Reset while a read is being acknowledged.
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE;
    @(negedge clk);
    checkOutput("mid_ack",  64'(bus.wbs_ack_o), 64'd1);
    checkOutput("mid_dat",  64'(bus.wbs_dat_o), 64'h0000_A5A5);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ack", 64'(bus.wbs_ack_o), 64'd0);
    checkOutput("mid_rst_dat", 64'(bus.wbs_dat_o), 64'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_out", 64'(io_out), 64'd0);
    checkOutput("mid_rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
